// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
//
// Memory-side responder for the cache's line-granular memory interface.
// Serves 128-bit line reads and writes from internal storage after a fixed,
// parameterised latency and signals completion with a one-cycle mem_resp.
// It serves as the physical-memory model beneath the L1 cache and as the
// backend stand-in for cache verification.
//
// Handshake: the initiator raises mem_read or mem_write and holds it, together
// with a stable mem_address (and mem_wdata for writes), until it sees mem_resp
// high for one cycle. A TURN cycle always follows mem_resp, during which the
// request lines are ignored, so a request still held from the completed
// transaction is never served twice.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (storage is never touched)
//   mem_read     line read request
//   mem_write    line write request
//   mem_address  line address {tag,set}
//   mem_wdata    write line
//   mem_rdata    read line, registered, valid in the mem_resp cycle of a read
//   mem_resp     one-cycle completion pulse
//   proto_err    sticky protocol-violation flag, cleared only by rst
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 128,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  proto_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Wait counter preset; 8 bits covers the legal latency range 1..255.
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    logic [1:0]            state;
    logic [7:0]            wait_cnt;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [LINE_WIDTH-1:0] lat_wdata;

    // All lines read as zero until first written.
    logic [LINE_WIDTH-1:0] storage [DEPTH] = '{default: '0};

    // The latched request kind is the one whose line must stay high in WAIT.
    logic req_dropped;
    logic req_changed;

    assign req_dropped = lat_write ? !mem_write : !mem_read;
    assign req_changed = (mem_address != lat_addr) ||
                         (lat_write && (mem_wdata != lat_wdata));

    assign mem_resp = (state == S_RESP);

    // Control path and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        // A simultaneous read+write is treated as a write.
                        lat_write <= mem_write;
                        lat_addr  <= mem_address;
                        lat_wdata <= mem_wdata;
                        if (mem_read && mem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state <= S_RESP;
                            // Load read data on the way into RESP so it is
                            // valid for the whole response cycle.
                            if (!mem_write) begin
                                mem_rdata <= storage[mem_address];
                            end
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (req_dropped) begin
                        // Initiator withdrew the request: abandon silently.
                        proto_err <= 1'b1;
                        state     <= S_IDLE;
                        wait_cnt  <= 8'd0;
                    end else begin
                        // Address/data wobble is flagged but the latched
                        // values are what the transaction completes with.
                        if (req_changed) begin
                            proto_err <= 1'b1;
                        end
                        wait_cnt <= wait_cnt - 8'd1;
                        if (wait_cnt == 8'd1) begin
                            state <= S_RESP;
                            if (!lat_write) begin
                                mem_rdata <= storage[lat_addr];
                            end
                        end
                    end
                end
                S_RESP: begin
                    state <= S_TURN;
                end
                S_TURN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write commit at the edge that ends RESP. A reset arriving on that edge
    // abandons the transaction, so it also suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_RESP) && lat_write) begin
            storage[lat_addr] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_line_mem_responder
//
// Directed bench for line_mem_responder. A table of read/write vectors with
// hand-computed expected data runs on a LATENCY=4 instance; hand-written
// sequences cover back-to-back held requests, abort, simultaneous request,
// reset mid-transaction, address wobble, and a LATENCY=1 instance.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_line_mem_responder;

    localparam int AW = 12;
    localparam int LW = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;

    // LATENCY=4 instance
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          proto_err;

    // LATENCY=1 instance
    logic          l1_read;
    logic          l1_write;
    logic [AW-1:0] l1_address;
    logic [LW-1:0] l1_wdata;
    logic [LW-1:0] l1_rdata;
    logic          l1_resp;
    logic          l1_err;

    line_mem_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .proto_err   (proto_err)
    );

    line_mem_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY(1)) dut_l1 (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (l1_read),
        .mem_write   (l1_write),
        .mem_address (l1_address),
        .mem_wdata   (l1_wdata),
        .mem_rdata   (l1_rdata),
        .mem_resp    (l1_resp),
        .proto_err   (l1_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LW-1:0] act,
                         input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
        mem_read    = rd;
        mem_write   = wr;
        mem_address = a;
        mem_wdata   = d;
    endtask

    // Counts falling edges until mem_resp; n = -1 if the budget runs out.
    task automatic wait_resp(input int max_cycles, output int n,
                             output logic [LW-1:0] rdata);
        n     = -1;
        rdata = '0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                n     = i;
                rdata = mem_rdata;
                break;
            end
        end
    endtask

    task automatic count_resp(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mem_resp) pulses++;
        end
    endtask

    // One full transaction starting in an IDLE cycle; returns through TURN.
    task automatic run_txn(input string name, input logic wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] d,
                           output int lat, output logic [LW-1:0] rdata);
        @(negedge clk);
        drive(!wr, wr, a, d);
        wait_resp(12, lat, rdata);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check({name, "_turn_resp"}, LW'(mem_resp), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_l1(output int n, output logic [LW-1:0] rdata);
        n     = -1;
        rdata = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (l1_resp) begin
                n     = i;
                rdata = l1_rdata;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    localparam logic [LW-1:0] D_BEEF = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [LW-1:0] D_HI   = 128'hA5A5_A5A5_0000_1111_2222_3333_A5A5_A5A5;
    localparam logic [LW-1:0] D_LO   = 128'h5A5A_5A5A_FFFF_EEEE_DDDD_CCCC_5A5A_5A5A;
    localparam logic [LW-1:0] D_NEW  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

    vec_t vecs[9];

    initial begin
        int            lat;
        int            pulses;
        logic [LW-1:0] rdata;
        logic [LW-1:0] last_rd;

        vecs[0] = '{1'b0, 12'h2A5, '0,     '0};      // cold read
        vecs[1] = '{1'b1, 12'h013, D_BEEF, '0};
        vecs[2] = '{1'b0, 12'h013, '0,     D_BEEF};
        vecs[3] = '{1'b1, 12'hFFF, D_HI,   '0};
        vecs[4] = '{1'b1, 12'h000, D_LO,   '0};
        vecs[5] = '{1'b0, 12'hFFF, '0,     D_HI};    // top line distinct
        vecs[6] = '{1'b0, 12'h000, '0,     D_LO};    // from line zero
        vecs[7] = '{1'b1, 12'h013, D_NEW,  '0};
        vecs[8] = '{1'b0, 12'h013, '0,     D_NEW};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        l1_read = 1'b0; l1_write = 1'b0; l1_address = '0; l1_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_resp",  LW'(mem_resp),  '0);
        check("reset_rdata", mem_rdata,      '0);
        check("reset_err",   LW'(proto_err), '0);
        rst = 1'b0;

        // ---- table-driven transactions, LATENCY=4 ----
        last_rd = '0;
        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, lat, rdata);
            check($sformatf("vec%0d_lat", i), LW'(lat), LW'(4));
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
                last_rd = vecs[i].exp_rdata;
            end else begin
                // Writes leave the previous read value on mem_rdata.
                check($sformatf("vec%0d_rdata_hold", i), rdata, last_rd);
            end
        end
        check("table_err", LW'(proto_err), '0);

        // ---- writeback then allocate, read held across TURN ----
        @(negedge clk);
        drive(1'b0, 1'b1, 12'h1F8, 128'h1);
        wait_resp(12, lat, rdata);
        check("wb_lat", LW'(lat), LW'(4));
        drive(1'b1, 1'b0, 12'h0F8, '0);          // raised in the RESP cycle
        wait_resp(12, lat, rdata);
        check("alloc_gap", LW'(lat), LW'(6));    // TURN, IDLE, 3 WAIT, RESP
        check("alloc_rdata", rdata, '0);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        run_txn("wb_back", 1'b0, 12'h1F8, '0, lat, rdata);
        check("wb_back_rdata", rdata, 128'h1);
        check("wb_err", LW'(proto_err), '0);

        // ---- abort: write dropped in cycle 2 ----
        @(negedge clk);
        drive(1'b0, 1'b1, 12'h055, '1);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        count_resp(10, pulses);
        check("abort_no_resp", LW'(pulses), '0);
        check("abort_err", LW'(proto_err), LW'(1));
        run_txn("abort_rd", 1'b0, 12'h055, '0, lat, rdata);
        check("abort_rd_rdata", rdata, '0);

        do_reset();
        check("rst_clears_err", LW'(proto_err), '0);

        // ---- simultaneous read+write served as write ----
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h066, 128'h77);
        wait_resp(12, lat, rdata);
        check("both_lat", LW'(lat), LW'(4));
        check("both_err", LW'(proto_err), LW'(1));
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        run_txn("both_rd", 1'b0, 12'h066, '0, lat, rdata);
        check("both_rd_rdata", rdata, 128'h77);

        do_reset();

        // ---- reset in cycle 2 of a write ----
        @(negedge clk);
        drive(1'b0, 1'b1, 12'h013, 128'hBAD);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        count_resp(8, pulses);
        check("rstmid_no_resp", LW'(pulses), '0);
        check("rstmid_err", LW'(proto_err), '0);
        run_txn("rstmid_rd", 1'b0, 12'h013, '0, lat, rdata);
        check("rstmid_rdata", rdata, D_NEW);

        // ---- address changes during WAIT: flagged, latched values win ----
        @(negedge clk);
        drive(1'b0, 1'b1, 12'h0A0, D_BEEF);
        @(negedge clk);
        mem_address = 12'h0A1;
        wait_resp(12, lat, rdata);
        check("wobble_lat", LW'(lat), LW'(3));
        check("wobble_err", LW'(proto_err), LW'(1));
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        run_txn("wobble_a0", 1'b0, 12'h0A0, '0, lat, rdata);
        check("wobble_a0_rdata", rdata, D_BEEF);
        run_txn("wobble_a1", 1'b0, 12'h0A1, '0, lat, rdata);
        check("wobble_a1_rdata", rdata, '0);

        // ---- LATENCY=1 instance ----
        @(negedge clk);
        l1_read = 1'b1; l1_address = 12'h2A5;
        wait_l1(lat, rdata);
        check("l1_rd_lat", LW'(lat), LW'(1));
        check("l1_rd_rdata", rdata, '0);
        l1_read = 1'b0;
        @(negedge clk);
        check("l1_turn_resp", LW'(l1_resp), '0);
        @(negedge clk);
        l1_write = 1'b1; l1_address = 12'h123; l1_wdata = D_HI;
        wait_l1(lat, rdata);
        check("l1_wr_lat", LW'(lat), LW'(1));
        l1_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        l1_read = 1'b1; l1_address = 12'h123;
        wait_l1(lat, rdata);
        check("l1_rd2_lat", LW'(lat), LW'(1));
        check("l1_rd2_rdata", rdata, D_HI);
        l1_read = 1'b0;
        check("l1_err", LW'(l1_err), '0);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
                 n_checks, n_fail);
        $fatal(1);
    end

endmodule
